// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame path: frame state encoding and parity helper.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2
  } state_t;

  localparam int unsigned MAX_WIDTH = 32;

  // Even parity bit: makes the total number of ones (word + parity) even.
  function automatic logic even_par(input logic [MAX_WIDTH-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_frame_loader_bit_counter.sv
// Data-bit index counter; saturates at WIDTH-1 and is reloaded to zero on each accepted word.
module bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          at_last
);

  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_r;

  // Count register: clear/reload to zero, step once per emitted data bit.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= '0;
    end else if (inc && !at_last) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt     = cnt_r;
  assign at_last = (cnt_r == LAST_C);

endmodule

// File: rtl/serial_frame_loader.sv
// Parallel-in, serial-out frame loader feeding the downstream shift register's serial input.
module serial_frame_loader
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             a,
  output logic             a_valid,
  output logic             frame_start,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] PENULT_C = CW'(WIDTH - 2);

  state_t                 state_r, state_nxt_s;
  logic [WIDTH-1:0]       shreg_r, shreg_nxt_s, shifted_s;
  logic [MAX_WIDTH-1:0]   word_ext_s;
  logic                   par_r;
  logic                   a_r, a_valid_r, frame_start_r, done_r;
  logic                   a_nxt_s, a_valid_nxt_s, frame_start_nxt_s, done_nxt_s;
  logic                   head_s;
  logic                   accept_s, load_s, inc_s, at_last_s;
  logic [CW-1:0]          cnt_s;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk     (clk),
    .clr     (clr),
    .load    (load_s),
    .inc     (inc_s),
    .cnt     (cnt_s),
    .at_last (at_last_s)
  );

  // A new word can be taken while idle or while the last bit of a frame is on the line.
  assign in_ready   = (state_r == IDLE) || done_r;
  assign accept_s   = in_valid && in_ready;
  assign word_ext_s = MAX_WIDTH'(in_data);

  // Shift direction follows the bit order so the bit on the line is always at the head.
  always_comb begin
    shifted_s = shreg_r;
    if (MSB_FIRST) begin
      shifted_s = {shreg_r[WIDTH-2:0], 1'b0};
    end else begin
      shifted_s = {1'b0, shreg_r[WIDTH-1:1]};
    end
  end

  // Next-state logic: the state names the kind of bit that will be on the line next cycle.
  always_comb begin
    state_nxt_s = state_r;
    shreg_nxt_s = shreg_r;
    load_s      = 1'b0;
    inc_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = DATA;
          shreg_nxt_s = in_data;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DATA: begin
        if (!at_last_s) begin
          state_nxt_s = DATA;
          shreg_nxt_s = shifted_s;
          inc_s       = 1'b1;
        end else if (PARITY_EN) begin
          state_nxt_s = PAR;
        end else if (accept_s) begin
          state_nxt_s = DATA;
          shreg_nxt_s = in_data;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PAR: begin
        if (accept_s) begin
          state_nxt_s = DATA;
          shreg_nxt_s = in_data;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output pre-computation: outputs are registered, so derive them from the next state.
  always_comb begin
    head_s            = MSB_FIRST ? shreg_nxt_s[WIDTH-1] : shreg_nxt_s[0];
    a_nxt_s           = 1'b0;
    a_valid_nxt_s     = 1'b0;
    frame_start_nxt_s = 1'b0;
    done_nxt_s        = 1'b0;
    case (state_nxt_s)
      DATA: begin
        a_nxt_s           = head_s;
        a_valid_nxt_s     = 1'b1;
        frame_start_nxt_s = load_s;
        // Next bit is the last data bit when the counter is about to reach WIDTH-1.
        done_nxt_s        = !PARITY_EN && inc_s && (cnt_s == PENULT_C);
      end
      PAR: begin
        a_nxt_s       = par_r;
        a_valid_nxt_s = 1'b1;
        done_nxt_s    = 1'b1;
      end
      IDLE: begin
        a_nxt_s = 1'b0;
      end
      default: begin
        a_nxt_s = 1'b0;
      end
    endcase
  end

  // State, word, parity and output registers; clr aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_r       <= IDLE;
      shreg_r       <= '0;
      par_r         <= 1'b0;
      a_r           <= 1'b0;
      a_valid_r     <= 1'b0;
      frame_start_r <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      shreg_r       <= shreg_nxt_s;
      par_r         <= load_s ? even_par(word_ext_s) : par_r;
      a_r           <= a_nxt_s;
      a_valid_r     <= a_valid_nxt_s;
      frame_start_r <= frame_start_nxt_s;
      done_r        <= done_nxt_s;
    end
  end

  assign a           = a_r;
  assign a_valid     = a_valid_r;
  assign frame_start = frame_start_r;
  assign done        = done_r;

endmodule

// File: doc/serial_frame_loader.md
# serial_frame_loader

Parallel-in, serial-out frame loader that sits directly upstream of the team's `shift_register` and drives its serial data input `a`. It accepts a `WIDTH`-bit word over a valid/ready handshake, then emits it one bit per `clk` cycle, optionally followed by an even-parity bit. It supports back-to-back frames with no idle gap, so the downstream shift register sees a continuous bit stream.

## Interface
Parameters:
- `WIDTH`, default 8: data word width, legal range 2..32.
- `MSB_FIRST`, default 1: 1 sends bit `WIDTH-1` first; 0 sends bit 0 first.
- `PARITY_EN`, default 1: 1 appends one even-parity bit after the data bits.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `in_data`  in  WIDTH: parallel word to send.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: loader can accept a word this cycle.
- `a`  out  1: serial bit to the shift register.
- `a_valid`  out  1: `a` carries a frame bit this cycle.
- `frame_start`  out  1: `a` is the first bit of a frame.
- `done`  out  1: `a` is the last bit of a frame (data MSB/LSB or parity).

## Operation
- States:
  - `IDLE`: no frame in progress.
  - `DATA`: emitting data bits.
  - `PAR`: emitting the parity bit (only when `PARITY_EN=1`).
- Accept: a transfer occurs on a rising edge where `in_valid && in_ready`. The loader then latches `in_data` into `shreg` and computes `par = ^in_data`.
- `in_ready` is combinational:
  - `(state==IDLE) || done`.
  - It is low during every other frame cycle.
- Transitions:
  - `IDLE` goes to `DATA` on accept.
  - `DATA` stays in `DATA` while `cnt != WIDTH-1`.
  - At `cnt==WIDTH-1`, `DATA` goes to `PAR` if `PARITY_EN`. Otherwise it goes to `DATA` on a simultaneous accept, or to `IDLE` without one.
  - `PAR` goes to `DATA` on a simultaneous accept, else to `IDLE`.
- Bit order:
  - `MSB_FIRST=1`: `a = shreg[WIDTH-1]`, and `shreg` shifts left with 0 filled in.
  - `MSB_FIRST=0`: `a = shreg[0]`, and `shreg` shifts right.
- Parity: even parity, so `a = par` in `PAR`. The data bits plus the parity bit always contain an even number of ones.
- Counter: `cnt` is `$clog2(WIDTH)` bits wide, cleared on accept, and incremented once per data bit. It never wraps past `WIDTH-1`; it is reloaded on the next accept.
- The `in_data` word is sampled only at accept. Changes while `in_ready=0` are ignored.
- `in_valid` asserted while `in_ready=0` is held off, not dropped. The upstream must keep `in_valid` high until accept.

## Timing
- Reset: on an edge with `clr=1`:
  - state goes to `IDLE`; `shreg`, `cnt` and `par` go to 0.
  - `a=0`, `a_valid=0`, `frame_start=0`, `done=0`.
  - `in_ready=1` from the first cycle after reset.
- A reset mid-frame aborts the frame immediately. No partial bits are emitted after the `clr` edge.
- `clr` has priority over an accept on the same edge.
- Latency: for an accept at edge N:
  - the first bit is valid in cycle N+1, with `frame_start=1`;
  - the frame occupies cycles N+1 .. N+L, where L = `WIDTH + PARITY_EN`;
  - `done=1` in cycle N+L.
- Back-to-back: an accept during the `done` cycle (edge N+L) makes the next frame's first bit appear in cycle N+L+1. There is no gap, and `a_valid` stays high.
- Idle: `a_valid=0` and `a=0` whenever no frame is in progress.
- `frame_start` and `done` are each a single-cycle pulse per frame.
- Throughput: one frame every L cycles with back-to-back input; never faster.

## Structure
- Shared package `serial_pkg`:
  - state encoding (`IDLE`, `DATA`, `PAR`), shared by downstream frame-aware blocks;
  - a parity function `even_par(word)`.
- One natural sub-module, `bit_counter`: a `$clog2(WIDTH)`-bit counter with `load`, `inc` and `at_last` outputs. The rest stays flat: FSM, `shreg`, output registers.
- All outputs except `in_ready` are registered.

## Test plan
- Reset: hold `clr=1` for 2 cycles with `in_valid=1`.
  - Required: `a_valid`, `frame_start`, `done` and `a` all 0.
  - Required: `in_ready=1` from the first cycle after `clr` falls.
  - Required: no accept during reset.
- Single frame, `WIDTH=8`, `MSB_FIRST=1`, `PARITY_EN=1`, `in_data=8'hA5`.
  - Required: `a` = 1,0,1,0,0,1,0,1 and then parity 0 over 9 consecutive cycles.
  - Required: `frame_start` in cycle 1 and `done` in cycle 9.
- LSB-first, odd parity data: `MSB_FIRST=0`, `in_data=8'h07`.
  - Required: `a` = 1,1,1,0,0,0,0,0 and then parity 1.
- Back-to-back: hold `in_valid=1` with `8'hFF` and then `8'h00`.
  - Required: 18 consecutive `a_valid` cycles reading 11111111,0 then 00000000,0.
  - Required: `in_ready` high only in `IDLE` and in the two `done` cycles.
- Reset mid-frame: assert `clr` during the 4th bit of `8'hA5`.
  - Required: `a_valid=0` from the next cycle.
  - Required: a following `8'h3C` frame is emitted cleanly as 0,0,1,1,1,1,0,0 then 0.
- No-parity variant: `PARITY_EN=0`, `in_data=8'h81`.
  - Required: 8-cycle frame 1,0,0,0,0,0,0,1.
  - Required: `done` on the 8th bit.
  - Required: a downstream `shift_register` fed from `a` holds `8'h81` after 8 bit cycles.
